// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode codes, flag bit positions and the packed result record.
package alu_pkg;

  localparam int ALU_DATA_W = 32;

  localparam logic [3:0] OP_OR   = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_NAND = 4'd2;
  localparam logic [3:0] OP_NOR  = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_ADD  = 4'd6;
  localparam logic [3:0] OP_SUB  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_CMP  = 4'd10;
  localparam logic [3:0] OP_ROL  = 4'd11;
  localparam logic [3:0] OP_ROR  = 4'd12;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] y;
    logic [3:0]            op;
    logic [3:0]            flags;
  } alu_result_t;

endpackage

// File: rtl/alu_result_queue_if.sv
// Producer-side (in_*) and consumer-side (out_*) valid/ready streams of the ALU result queue.
interface alu_result_queue_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_y;
  logic [3:0]        in_op;
  logic [3:0]        in_flags;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_y;
  logic [3:0]        out_op;
  logic [3:0]        out_flags;

  // The queue itself
  modport slave (
    input  in_valid, in_y, in_op, in_flags, out_ready,
    output in_ready, out_valid, out_y, out_op, out_flags
  );

  // The environment: ALU driving in_*, writeback consuming out_*
  modport master (
    output in_valid, in_y, in_op, in_flags, out_ready,
    input  in_ready, out_valid, out_y, out_op, out_flags
  );
endinterface

// File: rtl/alu_result_fifo.sv
// First-word fall-through FIFO: storage, wrapping pointers and occupancy count.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full, empty, push, pop;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign wr_ready = !full;
  assign rd_valid = !empty;
  // A full queue refuses the write even when the head is popped the same edge.
  assign push     = wr_valid & !full;
  assign pop      = rd_ready & !empty;

  // NOTE: every always_comb output is given its hold value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so all of them update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/alu_result_queue.sv
// ALU result queue: FIFO plus NZCV status, sticky overflow and optional statistics
// counters (enabled by defining ALU_RQ_STATS_EN).
module alu_result_queue
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_result_queue_if.slave      rq,
  input  logic                   clr_sticky,
  output logic [3:0]             status_nzcv,
  output logic                   sticky_ovf,
  output logic [$clog2(DEPTH):0] count,
  output logic [CNT_W-1:0]       ovf_cnt,
  output logic [CNT_W-1:0]       carry_cnt
);
  alu_result_t wr_res, rd_res;
  logic        push;
  logic [3:0]  status_q, status_d;
  logic        sticky_q, sticky_d;

  assign wr_res = '{y: rq.in_y, op: rq.in_op, flags: rq.in_flags};

  alu_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(alu_result_t))
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (rq.in_valid),
    .wr_ready (rq.in_ready),
    .wr_data  (wr_res),
    .rd_valid (rq.out_valid),
    .rd_ready (rq.out_ready),
    .rd_data  (rd_res),
    .count    (count)
  );

  assign rq.out_y     = rd_res.y;
  assign rq.out_op    = rd_res.op;
  assign rq.out_flags = rd_res.flags;
  assign push         = rq.in_valid & rq.in_ready;

  // A V=1 push in the same cycle as clr_sticky leaves the bit set.
  always_comb begin
    status_d = push ? rq.in_flags : status_q;
    sticky_d = (sticky_q & !clr_sticky) | (push & rq.in_flags[FLAG_V]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
      sticky_q <= 1'b0;
    end else begin
      status_q <= status_d;
      sticky_q <= sticky_d;
    end
  end

  assign status_nzcv = status_q;
  assign sticky_ovf  = sticky_q;

`ifdef ALU_RQ_STATS_EN
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d, carry_cnt_q, carry_cnt_d;
  logic [CNT_W-1:0] ovf_base, carry_base;

  // Clear first, then count this cycle's push, saturating at all-ones.
  always_comb begin
    ovf_base    = clr_sticky ? '0 : ovf_cnt_q;
    carry_base  = clr_sticky ? '0 : carry_cnt_q;
    ovf_cnt_d   = ovf_base;
    carry_cnt_d = carry_base;
    if (push && rq.in_flags[FLAG_V] && !(&ovf_base))   ovf_cnt_d   = ovf_base + 1'b1;
    if (push && rq.in_flags[FLAG_C] && !(&carry_base)) carry_cnt_d = carry_base + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_q   <= '0;
      carry_cnt_q <= '0;
    end else begin
      ovf_cnt_q   <= ovf_cnt_d;
      carry_cnt_q <= carry_cnt_d;
    end
  end

  assign ovf_cnt   = ovf_cnt_q;
  assign carry_cnt = carry_cnt_q;
`else
  assign ovf_cnt   = '0;
  assign carry_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed bench for alu_result_queue: vector table plus reset, wrap and statistics sequences.
module tb_alu_result_queue;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_sticky = 1'b0;
  logic [3:0]  status_nzcv;
  logic        sticky_ovf;
  logic [2:0]  count;
  logic [15:0] ovf_cnt, carry_cnt;

  int total = 0;
  int bad   = 0;

  alu_result_queue_if #(.DATA_W(32)) rq ();

  alu_result_queue #(.DEPTH(4), .DATA_W(32), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rq          (rq),
    .clr_sticky  (clr_sticky),
    .status_nzcv (status_nzcv),
    .sticky_ovf  (sticky_ovf),
    .count       (count),
    .ovf_cnt     (ovf_cnt),
    .carry_cnt   (carry_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        iv;
    logic [31:0] y;
    logic [3:0]  op;
    logic [3:0]  fl;
    logic        ordy;
    logic        clr;
    logic [2:0]  e_cnt;
    logic        e_ov;
    logic [31:0] e_y;
    logic [3:0]  e_op;
    logic        e_ir;
    logic [3:0]  e_st;
    logic        e_sk;
  } vec_t;

  vec_t vecs[22];

`ifdef ALU_RQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] y, input logic [3:0] op,
                       input logic [3:0] fl, input logic ordy, input logic clr);
    rq.in_valid  = iv;
    rq.in_y      = y;
    rq.in_op     = op;
    rq.in_flags  = fl;
    rq.out_ready = ordy;
    clr_sticky   = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] model_q[$];
  logic [31:0] nv;

  initial begin
    //            iv  y       op  fl  ordy clr  cnt ov  y       op  ir  st  sk
    vecs[0]  = '{1'b1, 32'h1,  4'd1, 4'h0, 1'b0, 1'b0, 3'd1, 1'b1, 32'h1,  4'd1, 1'b1, 4'h0, 1'b0};
    vecs[1]  = '{1'b1, 32'h2,  4'd2, 4'h0, 1'b0, 1'b0, 3'd2, 1'b1, 32'h1,  4'd1, 1'b1, 4'h0, 1'b0};
    vecs[2]  = '{1'b1, 32'h3,  4'd3, 4'h0, 1'b0, 1'b0, 3'd3, 1'b1, 32'h1,  4'd1, 1'b1, 4'h0, 1'b0};
    vecs[3]  = '{1'b1, 32'h4,  4'd4, 4'h0, 1'b0, 1'b0, 3'd4, 1'b1, 32'h1,  4'd1, 1'b0, 4'h0, 1'b0};
    vecs[4]  = '{1'b1, 32'h5,  4'd5, 4'h0, 1'b0, 1'b0, 3'd4, 1'b1, 32'h1,  4'd1, 1'b0, 4'h0, 1'b0};
    vecs[5]  = '{1'b0, 32'h0,  4'd0, 4'h0, 1'b1, 1'b0, 3'd3, 1'b1, 32'h2,  4'd2, 1'b1, 4'h0, 1'b0};
    vecs[6]  = '{1'b0, 32'h0,  4'd0, 4'h0, 1'b1, 1'b0, 3'd2, 1'b1, 32'h3,  4'd3, 1'b1, 4'h0, 1'b0};
    vecs[7]  = '{1'b0, 32'h0,  4'd0, 4'h0, 1'b1, 1'b0, 3'd1, 1'b1, 32'h4,  4'd4, 1'b1, 4'h0, 1'b0};
    vecs[8]  = '{1'b0, 32'h0,  4'd0, 4'h0, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0,  4'd0, 1'b1, 4'h0, 1'b0};
    vecs[9]  = '{1'b0, 32'h0,  4'd0, 4'h0, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0,  4'd0, 1'b1, 4'h0, 1'b0};
    vecs[10] = '{1'b1, 32'h10, 4'd6, 4'h2, 1'b0, 1'b0, 3'd1, 1'b1, 32'h10, 4'd6, 1'b1, 4'h2, 1'b0};
    vecs[11] = '{1'b1, 32'h11, 4'd7, 4'h2, 1'b0, 1'b0, 3'd2, 1'b1, 32'h10, 4'd6, 1'b1, 4'h2, 1'b0};
    vecs[12] = '{1'b1, 32'h12, 4'd8, 4'h2, 1'b0, 1'b0, 3'd3, 1'b1, 32'h10, 4'd6, 1'b1, 4'h2, 1'b0};
    vecs[13] = '{1'b1, 32'h13, 4'd9, 4'h2, 1'b0, 1'b0, 3'd4, 1'b1, 32'h10, 4'd6, 1'b0, 4'h2, 1'b0};
    // Full with pop: push refused, so status and sticky ignore its V flag.
    vecs[14] = '{1'b1, 32'h99, 4'd10,4'h1, 1'b1, 1'b0, 3'd3, 1'b1, 32'h11, 4'd7, 1'b1, 4'h2, 1'b0};
    vecs[15] = '{1'b0, 32'h0,  4'd0, 4'h0, 1'b1, 1'b0, 3'd2, 1'b1, 32'h12, 4'd8, 1'b1, 4'h2, 1'b0};
    vecs[16] = '{1'b0, 32'h0,  4'd0, 4'h0, 1'b1, 1'b0, 3'd1, 1'b1, 32'h13, 4'd9, 1'b1, 4'h2, 1'b0};
    vecs[17] = '{1'b0, 32'h0,  4'd0, 4'h0, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0,  4'd0, 1'b1, 4'h2, 1'b0};
    vecs[18] = '{1'b1, 32'h7,  4'd6, 4'h1, 1'b1, 1'b0, 3'd1, 1'b1, 32'h7,  4'd6, 1'b1, 4'h1, 1'b1};
    vecs[19] = '{1'b1, 32'h8,  4'd7, 4'h8, 1'b1, 1'b0, 3'd1, 1'b1, 32'h8,  4'd7, 1'b1, 4'h8, 1'b1};
    vecs[20] = '{1'b1, 32'h9,  4'd5, 4'h1, 1'b1, 1'b1, 3'd1, 1'b1, 32'h9,  4'd5, 1'b1, 4'h1, 1'b1};
    vecs[21] = '{1'b0, 32'h0,  4'd0, 4'h0, 1'b1, 1'b1, 3'd0, 1'b0, 32'h0,  4'd0, 1'b1, 4'h1, 1'b0};

    drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_count",    32'(count), 32'd0);
    check("rst_in_ready", 32'(rq.in_ready), 32'd1);
    check("rst_out_valid",32'(rq.out_valid), 32'd0);
    check("rst_out_y",    rq.out_y, 32'd0);
    check("rst_status",   32'(status_nzcv), 32'd0);
    check("rst_sticky",   32'(sticky_ovf), 32'd0);
    check("rst_ovf_cnt",  32'(ovf_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].iv, vecs[i].y, vecs[i].op, vecs[i].fl, vecs[i].ordy, vecs[i].clr);
      step();
      check($sformatf("v%0d_count", i),     32'(count),          32'(vecs[i].e_cnt));
      check($sformatf("v%0d_out_valid", i), 32'(rq.out_valid),   32'(vecs[i].e_ov));
      check($sformatf("v%0d_out_y", i),     rq.out_y,            vecs[i].e_y);
      check($sformatf("v%0d_out_op", i),    32'(rq.out_op),      32'(vecs[i].e_op));
      check($sformatf("v%0d_in_ready", i),  32'(rq.in_ready),    32'(vecs[i].e_ir));
      check($sformatf("v%0d_status", i),    32'(status_nzcv),    32'(vecs[i].e_st));
      check($sformatf("v%0d_sticky", i),    32'(sticky_ovf),     32'(vecs[i].e_sk));
    end
    check("empty_out_flags", 32'(rq.out_flags), 32'd0);

    // Concurrent push+pop at count=2, wrapping the 4-entry ring three times.
    model_q.delete();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h100 + 32'(i), OP_ADD, 4'h0, 1'b0, 1'b0);
      model_q.push_back(32'h100 + 32'(i));
      step();
    end
    check("conc_pre_count", 32'(count), 32'd2);
    for (int i = 0; i < 12; i++) begin
      nv = (i == 0) ? 32'hA5A5A5A5 : 32'h200 + 32'(i);
      drive(1'b1, nv, OP_SUB, 4'h0, 1'b1, 1'b0);
      void'(model_q.pop_front());
      model_q.push_back(nv);
      step();
      check($sformatf("conc%0d_count", i), 32'(count), 32'd2);
      check($sformatf("conc%0d_out_y", i), rq.out_y, model_q[0]);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b1, 1'b0);
      void'(model_q.pop_front());
      step();
      check($sformatf("conc_drain%0d_out_y", i), rq.out_y, (i == 0) ? model_q[0] : 32'd0);
    end
    check("conc_end_count", 32'(count), 32'd0);

    // Statistics: C in three pushes, V in two; tied to zero when the feature is off.
    drive(1'b1, 32'h1, OP_ADD, 4'h2, 1'b1, 1'b0); step();
    drive(1'b1, 32'h2, OP_ADD, 4'h3, 1'b1, 1'b0); step();
    drive(1'b1, 32'h3, OP_SUB, 4'h2, 1'b1, 1'b0); step();
    drive(1'b1, 32'h4, OP_SUB, 4'h1, 1'b1, 1'b0); step();
    check("stats_carry", 32'(carry_cnt), STATS ? 32'd3 : 32'd0);
    check("stats_ovf",   32'(ovf_cnt),   STATS ? 32'd2 : 32'd0);
    check("stats_sticky",32'(sticky_ovf), 32'd1);
    drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b1, 1'b1); step();
    check("stats_clr_carry", 32'(carry_cnt), 32'd0);
    check("stats_clr_ovf",   32'(ovf_cnt),   32'd0);
    check("stats_clr_sticky",32'(sticky_ovf), 32'd0);

    // Asynchronous reset with three entries queued.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h30 + 32'(i), OP_XOR, 4'h9, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    check("pre_rst_count", 32'(count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(rq.out_valid), 32'd0);
    check("mid_rst_count",     32'(count), 32'd0);
    check("mid_rst_status",    32'(status_nzcv), 32'd0);
    check("mid_rst_in_ready",  32'(rq.in_ready), 32'd1);
    check("mid_rst_sticky",    32'(sticky_ovf), 32'd0);
    check("mid_rst_out_y",     rq.out_y, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h55, OP_ROL, 4'h4, 1'b0, 1'b0);
    step();
    check("post_rst_count",     32'(count), 32'd1);
    check("post_rst_out_y",     rq.out_y, 32'h55);
    check("post_rst_out_flags", 32'(rq.out_flags), 32'h4);
    drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    step();
    check("hold_out_y", rq.out_y, 32'h55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
